// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer owning the PC and IR.
// Optional macro SEQ_TIMEOUT_EN: 16-cycle handshake timeout that halts the core with err set.
module multicycle_sequencer #(
  parameter int WIDTH   = 32,
  parameter int IMEM_AW = 7
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [31:0]       instr_in,
  output logic [31:0]       ir,
  input  logic              branch_taken,
  input  logic [WIDTH-1:0]  branch_target,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ack,
  output logic              rf_we,
  output logic [WIDTH-1:0]  pc,
  output logic [2:0]        state,
  output logic              halted,
  output logic              err
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [IMEM_AW-1:0] PC_ONE = 1;

  state_t             r_state;
  state_t             w_stateNext;
  logic [IMEM_AW-1:0] r_pc;
  logic [IMEM_AW-1:0] r_jump;
  logic [31:0]        r_ir;
  logic [IMEM_AW-1:0] w_pcNext;
  logic [IMEM_AW-1:0] w_pcInc;
  logic [IMEM_AW-1:0] w_target;
  logic               w_irLoad;
  logic               w_jumpLoad;
  logic               w_timeout;
  logic               w_unusedTargetBits;
  logic [6:0]         w_opcode;
  logic               w_isLoad;
  logic               w_isStore;
  logic               w_isBranch;
  logic               w_isJump;
  logic               w_isHalt;

  assign w_opcode   = r_ir[6:0];
  assign w_isLoad   = (w_opcode == 7'b0000011);
  assign w_isStore  = (w_opcode == 7'b0100011);
  assign w_isBranch = (w_opcode == 7'b1100011);
  assign w_isJump   = (w_opcode == 7'b1101111) || (w_opcode == 7'b1100111);
  assign w_isHalt   = (w_opcode == 7'b1111111);

  // Only the low IMEM_AW bits of a redirect address are meaningful
  assign w_pcInc            = r_pc + PC_ONE;
  assign w_target           = branch_target[IMEM_AW-1:0];
  assign w_unusedTargetBits = ^branch_target[WIDTH-1:IMEM_AW];

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_pcNext    = r_pc;
    w_irLoad    = 1'b0;
    w_jumpLoad  = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (imem_ack) begin
          w_irLoad    = 1'b1;
          w_stateNext = S_DECODE;
        end else if (w_timeout) begin
          w_stateNext = S_HALT;
        end
      end
      S_DECODE: w_stateNext = w_isHalt ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (w_isLoad || w_isStore) begin
          w_stateNext = S_MEM;
        end else if (w_isBranch) begin
          w_pcNext    = branch_taken ? w_target : w_pcInc;
          w_stateNext = S_FETCH;
        end else if (w_isJump) begin
          w_jumpLoad  = 1'b1;
          w_stateNext = S_WB;
        end else begin
          w_stateNext = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (w_isStore) begin
            w_pcNext    = w_pcInc;
            w_stateNext = S_FETCH;
          end else begin
            w_stateNext = S_WB;
          end
        end else if (w_timeout) begin
          w_stateNext = S_HALT;
        end
      end
      S_WB: begin
        w_pcNext    = w_isJump ? r_jump : w_pcInc;
        w_stateNext = S_FETCH;
      end
      S_HALT:  w_stateNext = S_HALT;
      default: w_stateNext = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc   <= '0;
      r_ir   <= '0;
      r_jump <= '0;
    end else begin
      r_pc <= w_pcNext;
      if (w_irLoad)   r_ir   <= instr_in;
      if (w_jumpLoad) r_jump <= w_target;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  logic [3:0] r_wait;
  logic       r_err;
  logic       w_waiting;

  // Counter is zero in every non-waiting cycle, so it starts clean on each FETCH/MEM entry
  assign w_waiting = ((r_state == S_FETCH) && !imem_ack) || ((r_state == S_MEM) && !dmem_ack);
  assign w_timeout = w_waiting && (r_wait == 4'hF);

  always_ff @(posedge clk) begin
    if (!rst)           r_wait <= '0;
    else if (w_waiting) r_wait <= r_wait + 4'd1;
    else                r_wait <= '0;
  end

  always_ff @(posedge clk) begin
    if (!rst)           r_err <= 1'b0;
    else if (w_timeout) r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  assign imem_req = (r_state == S_FETCH);
  assign dmem_req = (r_state == S_MEM);
  assign dmem_we  = (r_state == S_MEM) && w_isStore;
  assign rf_we    = (r_state == S_WB);
  assign halted   = (r_state == S_HALT);
  assign state    = r_state;
  assign ir       = r_ir;
  assign pc       = {{(WIDTH-IMEM_AW){1'b0}}, r_pc};

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: random instruction stream against a per-instruction model.
module tb_multicycle_sequencer;

  localparam int C_ALU = 0, C_LOAD = 1, C_STORE = 2, C_BRANCH = 3, C_JUMP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack;
  logic [31:0] instr_in, ir;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        dmem_req, dmem_we, dmem_ack, rf_we;
  logic [31:0] pc;
  logic [2:0]  state;
  logic        halted, err;

  always #5 clk = ~clk;

  multicycle_sequencer #(.WIDTH(32), .IMEM_AW(7)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_ack(imem_ack), .instr_in(instr_in), .ir(ir),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .pc(pc), .state(state), .halted(halted), .err(err)
  );

  typedef struct {
    int          cycles;
    logic [31:0] pc;
    int          rfPulses;
    int          storeCycles;
  } exp_t;

  exp_t       scoreQ[$];
  exp_t       monE;
  int         nChecks = 0;
  int         nFail = 0;
  logic [6:0] modelPc;
  bit         monitorOn = 0;
  int         cyc, rfCnt, dwCnt;
  logic       prevReq;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit isSpecial(input logic [6:0] op);
    return op == 7'b0000011 || op == 7'b0100011 || op == 7'b1100011 ||
           op == 7'b1101111 || op == 7'b1100111 || op == 7'b1111111;
  endfunction

  function automatic logic [6:0] opcodeFor(input int cls);
    logic [6:0] op;
    case (cls)
      C_LOAD:   op = 7'b0000011;
      C_STORE:  op = 7'b0100011;
      C_BRANCH: op = 7'b1100011;
      C_JUMP:   op = ($urandom_range(0, 1) == 1) ? 7'b1101111 : 7'b1100111;
      default: begin
        op = 7'(($urandom()));
        while (isSpecial(op)) op = 7'(($urandom()));
      end
    endcase
    return op;
  endfunction

  // Monitor: every fresh FETCH entry closes the previous instruction and is scored against the queue
  always @(posedge clk) begin
    #1;
    if (monitorOn) begin
      if (imem_req && !prevReq) begin
        if (scoreQ.size() == 0) begin
          checkOutput("scoreboard underflow", 32'd1, 32'd0);
        end else begin
          monE = scoreQ.pop_front();
          checkOutput("instr cycles", cyc, monE.cycles);
          checkOutput("next pc", pc, monE.pc);
          checkOutput("rf_we pulses", rfCnt, monE.rfPulses);
          checkOutput("dmem_we cycles", dwCnt, monE.storeCycles);
        end
        cyc = 1; rfCnt = 0; dwCnt = 0;
      end else begin
        cyc++;
        rfCnt += int'(rf_we);
        dwCnt += int'(dmem_we);
      end
      prevReq = imem_req;
    end
  end

  task automatic waitReq(input bit isData);
    for (int i = 0; i < 200; i++) begin
      if (isData ? dmem_req : imem_req) return;
      @(negedge clk);
    end
    checkOutput(isData ? "dmem_req wait" : "imem_req wait", 32'd0, 32'd1);
  endtask

  // Stray dmem_ack pulses during fetch waits must be ignored
  task automatic fetchWord(input logic [31:0] word, input logic bt, input logic [31:0] tgt, input int w1);
    waitReq(1'b0);
    repeat (w1) begin
      dmem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    dmem_ack = 1'b0;
    imem_ack = 1'b1;
    instr_in = word;
    branch_taken = bt;
    branch_target = tgt;
    @(negedge clk);
    imem_ack = 1'b0;
    instr_in = $urandom();
  endtask

  task automatic applyStimulus(input int cls, input logic bt, input logic [31:0] tgt, input int w1, input int w2);
    exp_t        e;
    logic [31:0] word;
    logic [6:0]  nxt;
    word = ($urandom() & 32'hFFFF_FF80) | {25'd0, opcodeFor(cls)};
    nxt = modelPc + 7'd1;
    if ((cls == C_BRANCH && bt) || cls == C_JUMP) nxt = tgt[6:0];
    case (cls)
      C_LOAD:   e.cycles = 5 + w1 + w2;
      C_STORE:  e.cycles = 4 + w1 + w2;
      C_BRANCH: e.cycles = 3 + w1;
      default:  e.cycles = 4 + w1;
    endcase
    e.pc = {25'd0, nxt};
    e.rfPulses = (cls == C_ALU || cls == C_LOAD || cls == C_JUMP) ? 1 : 0;
    e.storeCycles = (cls == C_STORE) ? 1 + w2 : 0;
    modelPc = nxt;
    scoreQ.push_back(e);
    fetchWord(word, bt, tgt, w1);
    if (cls == C_LOAD || cls == C_STORE) begin
      waitReq(1'b1);
      repeat (w2) begin
        imem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      imem_ack = 1'b0;
      dmem_ack = 1'b1;
      @(negedge clk);
      dmem_ack = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;
    bit moved;
    rst = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; instr_in = '0;
    branch_taken = 1'b0; branch_target = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset state", state, 0);
    checkOutput("reset pc", pc, 0);
    checkOutput("reset ir", ir, 0);
    checkOutput("reset halted", halted, 0);
    checkOutput("reset err", err, 0);
    checkOutput("reset rf_we", rf_we, 0);
    checkOutput("reset dmem_req", dmem_req, 0);
    checkOutput("reset dmem_we", dmem_we, 0);
    checkOutput("reset imem_req", imem_req, 1);

    rst = 1'b1;
    modelPc = '0;
    cyc = 1; rfCnt = 0; dwCnt = 0; prevReq = 1'b1;
    monitorOn = 1;

    applyStimulus(C_ALU, 1'b0, 32'h0, 0, 0);
    applyStimulus(C_LOAD, 1'b0, 32'h0, 0, 3);
    applyStimulus(C_BRANCH, 1'b1, 32'h45, 0, 0);
    applyStimulus(C_BRANCH, 1'b0, 32'h12, 1, 0);
    applyStimulus(C_JUMP, 1'b0, 32'h1FF, 0, 0);
    applyStimulus(C_ALU, 1'b0, 32'h0, 0, 0);
    applyStimulus(C_STORE, 1'b0, 32'h0, 2, 1);
    for (int i = 0; i < 60; i++)
      applyStimulus($urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom(),
                    $urandom_range(0, 3), $urandom_range(0, 3));

    fetchWord(32'hABCD_E07F, 1'b0, 32'h0, 1);
    for (int i = 0; i < 10 && !halted; i++) @(negedge clk);
    monitorOn = 0;
    checkOutput("scoreboard drained", scoreQ.size(), 0);
    checkOutput("halt halted", halted, 1);
    checkOutput("halt state", state, 5);
    checkOutput("halt pc", pc, {25'd0, modelPc});
    checkOutput("halt err", err, 0);
    seen = 0; moved = 0;
    imem_ack = 1'b1; dmem_ack = 1'b1;
    repeat (20) begin
      @(negedge clk);
      seen |= imem_req | dmem_req | rf_we;
      moved |= (pc != {25'd0, modelPc}) || !halted;
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    checkOutput("halt no requests", 32'(seen), 0);
    checkOutput("halt frozen", 32'(moved), 0);

    rst = 1'b0;
    @(negedge clk);
    checkOutput("halt reset state", state, 0);
    checkOutput("halt reset pc", pc, 0);
    checkOutput("halt reset halted", halted, 0);
    checkOutput("halt reset ir", ir, 0);
    rst = 1'b1;

    fetchWord(32'h0000_0003, 1'b0, 32'h0, 0);
    waitReq(1'b1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid-mem reset state", state, 0);
    checkOutput("mid-mem reset dmem_req", dmem_req, 0);
    checkOutput("mid-mem reset pc", pc, 0);
    checkOutput("mid-mem reset imem_req", imem_req, 1);
    rst = 1'b1;

`ifdef SEQ_TIMEOUT_EN
    repeat (15) @(negedge clk);
    checkOutput("timeout pre state", state, 0);
    checkOutput("timeout pre err", err, 0);
    @(negedge clk);
    checkOutput("timeout state", state, 5);
    checkOutput("timeout err", err, 1);
    checkOutput("timeout halted", halted, 1);
`else
    repeat (100) @(negedge clk);
    checkOutput("no-timeout state", state, 0);
    checkOutput("no-timeout err", err, 0);
    checkOutput("no-timeout imem_req", imem_req, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule
